pht_banked: RTL and testbench
=============================

Name: pht_banked

Overview:
- Parametrised successor to the local-history pattern history table in the fetch stage.
- Holds INDEXSIZE saturating counters of SATCNTWIDTH bits each.
- Serves NRD independent registered read ports, one per fetch slot, and takes one commit-time update per cycle.
- Initialises itself after reset with a sequential sweep, so no parallel per-entry reset logic is needed.

Parameters:
- INDEXSIZE, 4096, number of counter entries; must equal 2**LOGINDEXSIZE.
- LOGINDEXSIZE, 12, index width.
- SATCNTWIDTH, 2, counter width in bits; legal range 2..4.
- SATCNTINIT, 2'b10, counter value written by the init sweep; width SATCNTWIDTH.
- NRD, 2, number of read ports; legal range 1..4.

Ports:
- clock  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pht_rd_en_i  in  NRD  per-port read request.
- pht_rd_index_i  in  NRD*LOGINDEXSIZE  per-port read index; port k uses bits [k*LOGINDEXSIZE +: LOGINDEXSIZE].
- pht_br_pred_o  out  NRD  per-port predicted direction (counter MSB), registered.
- pht_rd_valid_o  out  NRD  per-port valid, one cycle after the request.
- pht_cm_brdir_we_i  in  1  commit-time update enable.
- pht_wt_index_i  in  LOGINDEXSIZE  entry to update.
- pht_cm_brdir_i  in  1  resolved direction of the retired branch; 1 = taken.
- pht_ready_o  out  1  table initialised; updates are accepted.

Behaviour:
- Reset (synchronous, while reset=1):
  - pht_br_pred_o=0, pht_rd_valid_o=0, pht_ready_o=0.
  - FSM goes to INIT with sweep pointer = 0.
  - Counter array contents are not reset directly.
- FSM state INIT:
  - Each cycle writes SATCNTINIT to entry[ptr], then ptr++.
  - When ptr==INDEXSIZE-1 is written, the next state is READY.
  - INIT therefore lasts exactly INDEXSIZE cycles after reset deasserts.
  - pht_ready_o rises in the first READY cycle.
- FSM state READY: terminal; left only by reset.
- Reset asserted mid-INIT: sweep restarts at ptr=0 on the cycle after reset deasserts.
- Reads in INIT:
  - The request is honoured: pht_rd_valid_o[k]=1 next cycle.
  - pht_br_pred_o[k]=SATCNTINIT[SATCNTWIDTH-1], regardless of array contents.
- Reads in READY:
  - Latency 1: request in cycle N gives pred/valid in cycle N+1.
  - If pht_rd_en_i[k]=0 in cycle N, valid[k]=0 in N+1 and pred[k] holds its previous value.
- Update in READY: single-cycle read-modify-write of entry[pht_wt_index_i].
  - Taken: cnt = (cnt==2^W-1) ? cnt : cnt+1.
  - Not taken: cnt = (cnt==0) ? 0 : cnt-1.
  - All arithmetic is unsigned, W=SATCNTWIDTH, with no wrap-around.
- Update in INIT: silently dropped; the sweep owns the write port.
- Back-to-back updates to the same index in consecutive cycles accumulate, since each sees the prior write.
- Write bypass: a read of index X in the same cycle as an update to X returns the post-update MSB in N+1.
- Multiple read ports on the same index: each returns an identical value, bypass included.
- All NRD ports are fully independent; there is no arbitration and no stall.

Optional Feature:
- Macro: PHT_CONF_OUT_EN.
- Defined:
  - Adds output pht_conf_o, NRD bits, registered alongside pred.
  - Bit k=1 when the read counter is saturated (0 or 2^W-1), bypass included.
  - Reset value 0; in INIT it reflects SATCNTINIT saturation.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Init timing (INDEXSIZE=16): deassert reset at cycle 0 -> pht_ready_o=0 through cycle 15, =1 at cycle 16. Then read all 16 entries -> every pred=1 (SATCNTINIT=2'b10).
- Saturation up: 3 taken updates to index 5, then read 5 -> pred=1; internal cnt=3, not 4 or 0; pht_conf_o=1 if enabled. Then 2 not-taken updates, read -> cnt=1, pred=0.
- Saturation down: 4 not-taken updates to index 7 -> cnt=0. A fifth not-taken update -> cnt stays 0, pred=0. One taken update -> cnt=1, pred=0.
- Bypass: entry 9 at cnt=1. In the same cycle, update 9 taken while port 0 and port 1 both read 9 -> next cycle valid=2'b11, pred=2'b11.
- Update during INIT: pulse pht_cm_brdir_we_i with index 2, not taken, at cycle 3 -> after ready, read 2 -> pred=1, cnt=2.
- Reset mid-sweep: assert reset at cycle 8 for 1 cycle -> pht_ready_o rises exactly 16 cycles after deassert. Outputs pred=0 and valid=0 during the reset cycle.

Source files
------------

// File: rtl/pht_banked.sv
// pht_banked: banked saturating-counter pattern history table, NRD registered read ports, one commit update per cycle.
// Define PHT_CONF_OUT_EN to add the per-port counter-saturation (confidence) output pht_conf_o.
module pht_banked #(
  parameter int INDEXSIZE = 4096,
  parameter int LOGINDEXSIZE = 12,
  parameter int SATCNTWIDTH = 2,
  parameter logic [SATCNTWIDTH-1:0] SATCNTINIT = 2'b10,
  parameter int NRD = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NRD-1:0]              pht_rd_en_i,
  input  logic [NRD*LOGINDEXSIZE-1:0] pht_rd_index_i,
  output logic [NRD-1:0]              pht_br_pred_o,
  output logic [NRD-1:0]              pht_rd_valid_o,
  input  logic                        pht_cm_brdir_we_i,
  input  logic [LOGINDEXSIZE-1:0]     pht_wt_index_i,
  input  logic                        pht_cm_brdir_i,
`ifdef PHT_CONF_OUT_EN
  output logic [NRD-1:0]              pht_conf_o,
`endif
  output logic                        pht_ready_o
);
  localparam logic [SATCNTWIDTH-1:0] CNT_MAX = '1;
  typedef enum logic {INIT, READY} state_e;
  state_e state_q, state_d;
  logic [LOGINDEXSIZE-1:0] ptr_q, ptr_d;
  logic [SATCNTWIDTH-1:0] mem_q [INDEXSIZE];
  logic cm_en, wr_en;
  logic [LOGINDEXSIZE-1:0] wr_addr;
  logic [SATCNTWIDTH-1:0] wr_data, cm_cnt, cm_upd;
  logic [SATCNTWIDTH-1:0] rd_cnt [NRD];
  logic [NRD-1:0] pred_q, pred_d, valid_q, valid_d;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INIT;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    if (state_q == INIT) begin
      ptr_d = ptr_q + 1'b1;
      state_d = (ptr_q == LOGINDEXSIZE'(INDEXSIZE - 1)) ? READY : INIT;
    end
  end
  // The sweep owns the write port until READY; commit updates are dropped meanwhile.
  always_comb begin
    pht_ready_o = state_q == READY;
    cm_en = pht_ready_o && pht_cm_brdir_we_i;
    wr_en = !pht_ready_o || pht_cm_brdir_we_i;
    wr_addr = pht_ready_o ? pht_wt_index_i : ptr_q;
    cm_cnt = mem_q[pht_wt_index_i];
    cm_upd = pht_cm_brdir_i ? ((cm_cnt == CNT_MAX) ? cm_cnt : cm_cnt + SATCNTWIDTH'(1))
                            : ((cm_cnt == '0) ? cm_cnt : cm_cnt - SATCNTWIDTH'(1));
    wr_data = pht_ready_o ? cm_upd : SATCNTINIT;
  end
  always_ff @(posedge clock) begin
    if (!reset && wr_en) mem_q[wr_addr] <= wr_data;
  end
  // Same-cycle update to the read index is forwarded so readers see the post-update counter.
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      rd_cnt[k] = !pht_ready_o ? SATCNTINIT
                : (cm_en && pht_rd_index_i[k*LOGINDEXSIZE +: LOGINDEXSIZE] == pht_wt_index_i) ? cm_upd
                : mem_q[pht_rd_index_i[k*LOGINDEXSIZE +: LOGINDEXSIZE]];
      pred_d[k] = pht_rd_en_i[k] ? rd_cnt[k][SATCNTWIDTH-1] : pred_q[k];
    end
    valid_d = pht_rd_en_i;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pred_q <= '0;
      valid_q <= '0;
    end else begin
      pred_q <= pred_d;
      valid_q <= valid_d;
    end
  end
  assign pht_br_pred_o = pred_q;
  assign pht_rd_valid_o = valid_q;
`ifdef PHT_CONF_OUT_EN
  logic [NRD-1:0] conf_q, conf_d;
  always_comb begin
    for (int k = 0; k < NRD; k++)
      conf_d[k] = pht_rd_en_i[k] ? (rd_cnt[k] == '0 || rd_cnt[k] == CNT_MAX) : conf_q[k];
  end
  always_ff @(posedge clock) begin
    if (reset) conf_q <= '0;
    else conf_q <= conf_d;
  end
  assign pht_conf_o = conf_q;
`endif
endmodule

// File: tb/tb_pht_banked.sv
// tb_pht_banked: directed self-checking bench for pht_banked with a 16-entry table and two read ports.
module tb_pht_banked;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0] rd_en = '0;
  logic [7:0] rd_idx = '0;
  logic [1:0] pred, valid;
  logic we = 1'b0;
  logic [3:0] wt_idx = '0;
  logic brdir = 1'b0;
  logic ready;
`ifdef PHT_CONF_OUT_EN
  logic [1:0] conf;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  pht_banked #(.INDEXSIZE(16), .LOGINDEXSIZE(4), .SATCNTWIDTH(2), .SATCNTINIT(2'b10), .NRD(2)) dut (
    .clock(clock),
    .reset(reset),
    .pht_rd_en_i(rd_en),
    .pht_rd_index_i(rd_idx),
    .pht_br_pred_o(pred),
    .pht_rd_valid_o(valid),
    .pht_cm_brdir_we_i(we),
    .pht_wt_index_i(wt_idx),
    .pht_cm_brdir_i(brdir),
`ifdef PHT_CONF_OUT_EN
    .pht_conf_o(conf),
`endif
    .pht_ready_o(ready)
  );
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic upd(input logic [3:0] i, input logic d);
    we = 1'b1;
    wt_idx = i;
    brdir = d;
    tick();
    we = 1'b0;
  endtask
  task automatic rd(input logic [3:0] i0, input logic [3:0] i1);
    rd_en = 2'b11;
    rd_idx = {i1, i0};
    tick();
    rd_en = 2'b00;
  endtask
  initial begin
    tick(); tick(); tick();
    chk("rst_pred", 32'(pred), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_ready", 32'(ready), 0);
    reset = 1'b0;
    for (int c = 0; c < 16; c++) begin
      we = (c == 3);
      wt_idx = 4'd2;
      brdir = 1'b0;
      rd_en = (c == 5) ? 2'b11 : 2'b00;
      rd_idx = {4'd14, 4'd1};
      tick();
      chk("init_ready", 32'(ready), 32'(c == 15));
      if (c == 5) begin
        chk("init_rd_valid", 32'(valid), 2'b11);
        chk("init_rd_pred", 32'(pred), 2'b11);
`ifdef PHT_CONF_OUT_EN
        chk("init_rd_conf", 32'(conf), 2'b00);
`endif
      end
      if (c == 6) begin
        chk("init_hold_valid", 32'(valid), 2'b00);
        chk("init_hold_pred", 32'(pred), 2'b11);
      end
    end
    for (int e = 0; e < 16; e++) begin
      rd(4'(e), 4'(15 - e));
      chk("sweep_valid", 32'(valid), 2'b11);
      chk("sweep_pred", 32'(pred), 2'b11);
    end
    upd(4'd5, 1'b1); upd(4'd5, 1'b1); upd(4'd5, 1'b1);
    rd(4'd5, 4'd5);
    chk("satup_pred", 32'(pred), 2'b11);
`ifdef PHT_CONF_OUT_EN
    chk("satup_conf", 32'(conf), 2'b11);
`endif
    upd(4'd5, 1'b0);
    rd(4'd5, 4'd5);
    chk("satup_dec1_pred", 32'(pred), 2'b11);
`ifdef PHT_CONF_OUT_EN
    chk("satup_dec1_conf", 32'(conf), 2'b00);
`endif
    upd(4'd5, 1'b0);
    rd(4'd5, 4'd5);
    chk("satup_dec2_pred", 32'(pred), 2'b00);
    upd(4'd7, 1'b0); upd(4'd7, 1'b0); upd(4'd7, 1'b0); upd(4'd7, 1'b0);
    rd(4'd7, 4'd7);
    chk("satdn_pred", 32'(pred), 2'b00);
`ifdef PHT_CONF_OUT_EN
    chk("satdn_conf", 32'(conf), 2'b11);
`endif
    upd(4'd7, 1'b0);
    upd(4'd7, 1'b1);
    rd(4'd7, 4'd7);
    chk("satdn_inc1_pred", 32'(pred), 2'b00);
    upd(4'd7, 1'b1);
    rd(4'd7, 4'd7);
    chk("satdn_inc2_pred", 32'(pred), 2'b11);
    upd(4'd9, 1'b0);
    we = 1'b1; wt_idx = 4'd9; brdir = 1'b1;
    rd_en = 2'b11; rd_idx = {4'd9, 4'd9};
    tick();
    we = 1'b0; rd_en = 2'b00;
    chk("bypass_valid", 32'(valid), 2'b11);
    chk("bypass_pred", 32'(pred), 2'b11);
    we = 1'b1; wt_idx = 4'd9; brdir = 1'b0;
    rd_en = 2'b11; rd_idx = {4'd3, 4'd9};
    tick();
    we = 1'b0; rd_en = 2'b00;
    chk("bypass_nt_pred", 32'(pred), 2'b10);
    rd_en = 2'b01; rd_idx = {4'd0, 4'd5};
    tick();
    rd_en = 2'b00;
    chk("hold_valid", 32'(valid), 2'b01);
    chk("hold_pred", 32'(pred), 2'b10);
    rd(4'd2, 4'd2);
    chk("initupd_pred", 32'(pred), 2'b11);
    upd(4'd2, 1'b0);
    rd(4'd2, 4'd2);
    chk("initupd_dec_pred", 32'(pred), 2'b00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      rd_en = (c == 6) ? 2'b11 : 2'b00;
      rd_idx = '0;
      tick();
    end
    chk("midrst_pre_pred", 32'(pred), 2'b11);
    reset = 1'b1;
    rd_en = 2'b11;
    tick();
    reset = 1'b0;
    rd_en = 2'b00;
    chk("midrst_pred", 32'(pred), 0);
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_ready", 32'(ready), 0);
    for (int c = 0; c < 16; c++) begin
      tick();
      chk("midrst_ready_seq", 32'(ready), 32'(c == 15));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
